// File: rtl/conv1_window_gen.sv
// Streaming 3x3x3 window generator for conv1: two line buffers plus a 3x3 shift window.
// Optional macro CONV1_WINDOW_GEN_STRIDE2_EN emits only even-row/even-col windows (stride 2).
module conv1_window_gen #(
  parameter int unsigned IMG_W = 16,
  parameter int unsigned IMG_H = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  input  logic         in_sof,
  input  logic [47:0]  in_pixel,
  output logic         window_valid,
  output logic [431:0] window_act,
  output logic         frame_done
);

  localparam int unsigned CH_W   = 16;
  localparam int unsigned N_CH   = 3;
  localparam int unsigned PIX_W  = CH_W * N_CH;
  localparam int unsigned K_DIM  = 3;
  localparam int unsigned CH_ACT = CH_W * K_DIM * K_DIM;
  localparam int unsigned ACT_W  = CH_ACT * N_CH;
  localparam int unsigned COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [COL_W-1:0] col, cur_col, nxt_col;
  logic [ROW_W-1:0] row, cur_row, nxt_row;
  logic             last_col, last_row, emit;

  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] lb2 [IMG_W];
  logic [PIX_W-1:0] lb1_rd, lb2_rd;

  logic [K_DIM-1:0][K_DIM-1:0][PIX_W-1:0] win, win_nxt;
  logic [ACT_W-1:0]                       act_nxt;

  // Position of the current beat (in_sof forces pixel (0,0)) and its successor.
  always_comb begin
    cur_col = col;
    cur_row = row;
    if (in_sof) begin
      cur_col = '0;
      cur_row = '0;
    end
    last_col = (cur_col == COL_W'(IMG_W - 1));
    last_row = (cur_row == ROW_W'(IMG_H - 1));
    nxt_col  = last_col ? '0 : cur_col + COL_W'(1);
    nxt_row  = cur_row;
    if (last_col) begin
      nxt_row = last_row ? '0 : cur_row + ROW_W'(1);
    end
  end

  // A window is complete once two full rows and two columns precede this pixel.
  always_comb begin
    emit = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
`ifdef CONV1_WINDOW_GEN_STRIDE2_EN
    emit = emit && !cur_row[0] && !cur_col[0];
`endif
  end

  assign lb1_rd = lb1[cur_col];
  assign lb2_rd = lb2[cur_col];

  // Shift the window left; the new right column is rows r-2, r-1, r at this column.
  always_comb begin
    win_nxt = win;
    for (int ky = 0; ky < int'(K_DIM); ky++) begin
      win_nxt[ky][0] = win[ky][1];
      win_nxt[ky][1] = win[ky][2];
    end
    win_nxt[0][2] = lb2_rd;
    win_nxt[1][2] = lb1_rd;
    win_nxt[2][2] = in_pixel;
  end

  // Pack channel-major, then tap k = ky*3+kx within each channel.
  always_comb begin
    act_nxt = '0;
    for (int c = 0; c < int'(N_CH); c++) begin
      for (int ky = 0; ky < int'(K_DIM); ky++) begin
        for (int kx = 0; kx < int'(K_DIM); kx++) begin
          act_nxt[c*CH_ACT + (ky*K_DIM + kx)*CH_W +: CH_W] = win_nxt[ky][kx][c*CH_W +: CH_W];
        end
      end
    end
  end

  // Line buffers are never cleared: stale entries only feed windows that are never emitted.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb2[cur_col] <= lb1_rd;
      lb1[cur_col] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col          <= '0;
      row          <= '0;
      win          <= '0;
      window_valid <= 1'b0;
      window_act   <= '0;
      frame_done   <= 1'b0;
    end else begin
      window_valid <= in_valid && emit;
      frame_done   <= in_valid && last_col && last_row;
      if (in_valid) begin
        col <= nxt_col;
        row <= nxt_row;
        win <= win_nxt;
        if (emit) begin
          window_act <= act_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv1_window_gen.sv
// Self-checking bench for conv1_window_gen: 4x4 image, directed frames plus random pixels/gaps.
module tb_conv1_window_gen;

  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int NPIX  = IMG_W * IMG_H;
`ifdef CONV1_WINDOW_GEN_STRIDE2_EN
  localparam int WPF = 1;
`else
  localparam int WPF = 4;
`endif

  logic         clk;
  logic         rstn;
  logic         in_valid;
  logic         in_sof;
  logic [47:0]  in_pixel;
  logic         window_valid;
  logic [431:0] window_act;
  logic         frame_done;

  conv1_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_valid     (in_valid),
    .in_sof       (in_sof),
    .in_pixel     (in_pixel),
    .window_valid (window_valid),
    .window_act   (window_act),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int nwin   = 0;
  int nfd    = 0;

  // Reference model: the current frame as a 2-D image indexed by raster position.
  logic [47:0]  img [IMG_H][IMG_W];
  int           pos = 0;
  logic [431:0] exp_act = '0;

  task automatic chk(input string tag, input logic [431:0] obs, input logic [431:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] ramp(input int p);
    ramp = {16'(4*p + 2), 16'(4*p + 1), 16'(4*p)};
  endfunction

  task automatic model_beat(input logic sof, input logic [47:0] px,
                            output logic ev, output logic efd);
    int r, c;
    if (sof) pos = 0;
    r = pos / IMG_W;
    c = pos % IMG_W;
    img[r][c] = px;
    ev = (r >= 2) && (c >= 2);
`ifdef CONV1_WINDOW_GEN_STRIDE2_EN
    ev = ev && (r % 2 == 0) && (c % 2 == 0);
`endif
    if (ev) begin
      for (int ch = 0; ch < 3; ch++)
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++)
            exp_act[144*ch + 16*(ky*3 + kx) +: 16] = img[r-2+ky][c-2+kx][16*ch +: 16];
    end
    efd = (pos == NPIX - 1);
    pos = (pos + 1) % NPIX;
  endtask

  // One clock: drive a beat (or bubble), then check all outputs #1 after the edge.
  task automatic step(input logic v, input logic s, input logic [47:0] px);
    logic ev, efd;
    ev = 1'b0;
    efd = 1'b0;
    in_valid = v;
    in_sof   = s;
    in_pixel = px;
    if (v) model_beat(s, px, ev, efd);
    @(posedge clk);
    #1;
    chk("window_valid", 432'(window_valid), 432'(ev));
    chk("frame_done", 432'(frame_done), 432'(efd));
    chk("window_act", window_act, exp_act);
    if (window_valid) nwin++;
    if (frame_done) nfd++;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    pos = 0;
    exp_act = '0;
    @(posedge clk);
    #1;
    chk("rst_window_valid", 432'(window_valid), 432'(0));
    chk("rst_frame_done", 432'(frame_done), 432'(0));
    chk("rst_window_act", window_act, 432'(0));
    @(negedge clk);
    rstn = 1'b1;
    #1;
  endtask

  task automatic chk_counts(input string tag, input int ew, input int ef);
    chk({tag, "_windows"}, 432'(nwin), 432'(ew));
    chk({tag, "_frame_done"}, 432'(nfd), 432'(ef));
    nwin = 0;
    nfd  = 0;
  endtask

  initial begin
    rstn = 1'b0;
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_pixel = '0;
    #2;
    apply_reset();

    // Continuous ramp frame; window at p=10 checked against hand values.
    for (int p = 0; p < NPIX; p++) begin
      step(1'b1, p == 0, ramp(p));
      if (p == 10) begin
        chk("p10_valid", 432'(window_valid), 432'(1));
        chk("p10_ch0_tap0", 432'(window_act[15:0]), 432'(0));
        chk("p10_ch0_tap8", 432'(window_act[143:128]), 432'(40));
        chk("p10_ch1_tap0", 432'(window_act[159:144]), 432'(1));
        chk("p10_ch2_tap8", 432'(window_act[431:416]), 432'(42));
      end
    end
    chk_counts("ramp", WPF, 1);
    repeat (2) step(1'b0, 1'b0, '0);

    // Same frame with a bubble between every beat.
    for (int p = 0; p < NPIX; p++) begin
      step(1'b1, p == 0, ramp(p));
      step(1'b0, 1'b0, 48'hFFFF_FFFF_FFFF);
    end
    chk_counts("gapped", WPF, 1);

    // Random pixels, random gaps, frames back-to-back without in_sof.
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < NPIX; p++) begin
        while ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 48'({$urandom, $urandom}));
        step(1'b1, (f == 0) && (p == 0), 48'({$urandom, $urandom}));
      end
    end
    chk_counts("random", 3 * WPF, 3);

    // in_sof on beat 7 abandons the partial frame; new frame is 16 beats.
    for (int p = 0; p < 6; p++) step(1'b1, p == 0, 48'({$urandom, $urandom}));
    for (int p = 0; p < NPIX; p++) step(1'b1, p == 0, 48'({$urandom, $urandom}));
    chk_counts("midsof", WPF, 1);

    // Reset after beat 9, then a frame with in_sof never asserted.
    for (int p = 0; p < 9; p++) step(1'b1, p == 0, ramp(p + 100));
    nwin = 0;
    nfd  = 0;
    apply_reset();
    for (int p = 0; p < NPIX; p++) step(1'b1, 1'b0, 48'({$urandom, $urandom}));
    chk_counts("post_reset", WPF, 1);

    // Idle cycles must hold window_act and assert nothing.
    repeat (4) step(1'b0, 1'b0, 48'({$urandom, $urandom}));
    chk_counts("idle", 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
